seq_chunk_adder: RTL and testbench



---
 rtl/seq_chunk_adder_if.sv | 29 ++
 rtl/seq_chunk_adder.sv | 104 ++++++++++
 tb/tb_seq_chunk_adder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // the sender holds its payload stable while valid is high and ready is low.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB chunk first,
// with carry rippling between chunks through a register.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_chunk_adder_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             last_chunk;
  int               sum_base;

  // a_q/b_q shift right each CALC cycle, so the current chunk is always in the low bits.
  always_comb begin
    {c_chunk, s_chunk} = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, carry_q};
    sum_base   = int'(cnt_q) * CHUNK;
    last_chunk = (cnt_q == CW'(NCH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.sub ? ~bus.b : bus.b;
            carry_q    <= bus.sub ? ~bus.cin : bus.cin;
            sum_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          sum_q[sum_base +: CHUNK] <= s_chunk;
          carry_q <= c_chunk;
          cnt_q   <= cnt_q + 1'b1;
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          if (last_chunk) begin
            // Low bits of a_q/b_q now hold the operand MSB chunk.
            cout_q      <= c_chunk;
            ovf_q       <= (a_q[CHUNK-1] == b_q[CHUNK-1]) && (s_chunk[CHUNK-1] != a_q[CHUNK-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder (WIDTH=16, CHUNK=4): directed corner cases,
// backpressure, mid-operation reset and randomized operations against an arithmetic model.
module tb_seq_chunk_adder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NCH   = WIDTH / CHUNK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;
  logic [17:0] exp_q[$];

  seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    int ux, uy, sx, sy, ru, rs;
    logic co, ov;
    logic [15:0] r;
    ux = int'({16'b0, x});
    uy = int'({16'b0, y});
    sx = int'($signed(x));
    sy = int'($signed(y));
    ru = s ? (ux - uy - int'(c)) : (ux + uy + int'(c));
    rs = s ? (sx - sy - int'(c)) : (sx + sy + int'(c));
    co = s ? (ru >= 0) : (ru > 65535);
    ov = (rs > 32767) || (rs < -32768);
    r  = ru[15:0];
    return {ov, co, r};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [17:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got sum=0x%0h with nothing expected", bus.sum);
        end else begin
          exp = exp_q.pop_front();
          check("result", {bus.ovf, bus.cout, bus.sum}, exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the edge following the result handshake.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic ts, input int hold, input bit toggle);
    int guard;
    logic [17:0] exp;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_wait", bus.in_ready, 1);
    exp = model(ta, tb_v, tc, ts);
    bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.sub = ts;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      check("calc_out_valid", bus.out_valid, 0);
      check("calc_in_ready", bus.in_ready, 0);
      if (toggle) begin
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
        bus.in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    check("latency_out_valid", bus.out_valid, 1);
    if (toggle) bus.in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_result", {bus.ovf, bus.cout, bus.sum}, exp);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("post_hs_in_ready", bus.in_ready, 1);
    check("post_hs_out_valid", bus.out_valid, 0);
    check("post_hs_state", dbg_state, 0);
    check("post_hs_result_held", {bus.ovf, bus.cout, bus.sum}, exp);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] dir_a  [11] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000,
                               16'h0005, 16'h8000, 16'h0010, 16'hABCD, 16'h0000, 16'h8000};
  logic [15:0] dir_b  [11] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000,
                               16'h0007, 16'h0001, 16'h0001, 16'h1357, 16'h8000, 16'h8000};
  logic        dir_c  [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        dir_s  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int          dir_h  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0};
  bit          dir_t  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  initial begin
    logic [15:0] ra, rb;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Last directed entry (0x8000+0x8000) leaves cout=1 before the mid-operation reset.
    for (int i = 0; i < 11; i++)
      run_op(dir_a[i], dir_b[i], dir_c[i], dir_s[i], dir_h[i], dir_t[i]);

    // Abort 0xFFFF+0x0001 after two chunks; no result may be presented.
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_state_calc", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_sum", bus.sum, 0);
    check("mid_rst_cout", bus.cout, 0);
    check("mid_rst_ovf", bus.ovf, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
